// File: rtl/write_demux_4_pkg.sv
// Shared types and constants for the 1-to-4 write demultiplexer.
// Holds the FSM state encoding and the stall-counter width.
package write_demux_4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int unsigned STALL_W = 8;

    typedef logic [STALL_W-1:0] stall_cnt_t;

    localparam int unsigned NUM_DEST = 4;

    // One-hot decode of a 2-bit destination index, forced to zero when disabled.
    function automatic logic [NUM_DEST-1:0] onehot4(input logic [1:0] sel, input logic en);
        logic [NUM_DEST-1:0] v;
        v = '0;
        if (en) begin
            v[sel] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/write_demux_4_decoder.sv
// 2-to-4 one-hot decoder with enable; drives the per-destination Valid vector.
module Decoder_2to4
    import write_demux_4_pkg::*;
(
    input  logic [1:0]          i_sel,
    input  logic                i_en,
    output logic [NUM_DEST-1:0] o_onehot
);

    always_comb begin
        o_onehot = onehot4(i_sel, i_en);
    end

endmodule

// File: rtl/write_demux_4.sv
// Single-entry write demultiplexer: holds one word and offers it to one of
// four destinations, dropping it if the destination stalls for TIMEOUT cycles.
module write_demux_4
    import write_demux_4_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [1:0]   Select,
    input  logic [N-1:0] In,
    output logic [N-1:0] Out0,
    output logic [N-1:0] Out1,
    output logic [N-1:0] Out2,
    output logic [N-1:0] Out3,
    output logic [3:0]   Valid,
    input  logic [3:0]   Ready,
    output logic         Drop
);

    localparam stall_cnt_t TIMEOUT_M1 = stall_cnt_t'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [N-1:0] r_data;
    logic [1:0] r_sel;
    stall_cnt_t r_cnt;
    stall_cnt_t w_cnt_nxt;
    logic       r_drop;
    logic       w_drop_nxt;

    logic       w_hold;
    logic       w_handshake;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_timeout;

    always_comb begin
        w_hold      = (r_state == ST_HOLD);
        w_handshake = w_hold && Ready[r_sel];
        // The drop cycle sits in IDLE but must not accept a new word.
        w_in_ready  = ((r_state == ST_IDLE) && !r_drop) || w_handshake;
        w_accept    = In_Valid && w_in_ready;
        w_timeout   = w_hold && !w_handshake && (r_cnt == TIMEOUT_M1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt = w_accept ? ST_HOLD : ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_drop_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_accept) begin
            w_cnt_nxt = '0;
        end else if (w_hold && !w_handshake) begin
            w_cnt_nxt = r_cnt + stall_cnt_t'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_data <= '0;
            r_sel  <= '0;
        end else if (w_accept) begin
            r_data <= In;
            r_sel  <= Select;
        end
    end

    Decoder_2to4 u_decoder (
        .i_sel    (r_sel),
        .i_en     (w_hold),
        .o_onehot (Valid)
    );

    assign In_Ready = w_in_ready;
    assign Out0     = r_data;
    assign Out1     = r_data;
    assign Out2     = r_data;
    assign Out3     = r_data;
    assign Drop     = r_drop;

endmodule
